// File: rtl/ahb_lite_req_master_pkg.sv
// Shared AHB-Lite encodings and default widths for the request master.
// Also holds the alignment helper used by the request-port assertion.
package ahb_lite_req_master_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_NONSEQ = 2'b10
    } htrans_e;

    localparam logic [2:0] HBURST_SINGLE   = 3'b000;
    localparam logic [2:0] HSIZE_BYTE      = 3'd0;
    localparam logic [2:0] HSIZE_HALF      = 3'd1;
    localparam logic [2:0] HSIZE_WORD      = 3'd2;
    localparam logic [3:0] HPROT_DATA_PRIV = 4'b0011;
    localparam logic       HRESP_OKAY      = 1'b0;
    localparam logic       HRESP_ERROR     = 1'b1;

    // Only the low address byte matters for sizes up to 128 bytes.
    function automatic logic is_aligned(input logic [7:0] addr_lo, input logic [2:0] size);
        logic [7:0] mask;
        mask = (8'd1 << size) - 8'd1;
        return (addr_lo & mask) == 8'd0;
    endfunction

endpackage

// File: rtl/ahb_lite_req_master.sv
// Single-beat AHB-Lite master: valid/ready requests in, NONSEQ/SINGLE transfers out,
// in-order responses back. Two pipeline stages (address, data) plus the ERROR flag err2.
module ahb_lite_req_master
    import ahb_lite_req_master_pkg::*;
#(
    parameter int ADDR = ADDR_W,
    parameter int DATA = DATA_W
) (
    input  logic            hclk,
    input  logic            hreset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_write,
    input  logic [ADDR-1:0] req_addr,
    input  logic [2:0]      req_size,
    input  logic [DATA-1:0] req_wdata,
    output logic            rsp_valid,
    output logic [DATA-1:0] rsp_rdata,
    output logic            rsp_err,
    output logic [1:0]      htrans,
    output logic [2:0]      hburst,
    output logic [2:0]      hsize,
    output logic [3:0]      hprot,
    output logic            hmastlock,
    output logic [ADDR-1:0] haddr,
    output logic            hwrite,
    output logic [DATA-1:0] hwdata,
    input  logic [DATA-1:0] hrdata,
    input  logic            hresp,
    input  logic            hready
);

    localparam int MAX_SIZE = $clog2(DATA / 8);

    logic            aph_valid_q, aph_valid_d;
    logic [ADDR-1:0] aph_addr_q,  aph_addr_d;
    logic [2:0]      aph_size_q,  aph_size_d;
    logic            aph_write_q, aph_write_d;
    logic [DATA-1:0] aph_wdata_q, aph_wdata_d;
    logic            dph_valid_q, dph_valid_d;
    logic            dph_write_q, dph_write_d;
    logic [DATA-1:0] dph_wdata_q, dph_wdata_d;
    logic            err2_q,      err2_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic            rsp_err_q,   rsp_err_d;
    logic [DATA-1:0] rsp_rdata_q, rsp_rdata_d;

    logic err_first;
    logic accept;
    logic done;

    always_comb begin
        err_first = dph_valid_q & hresp & ~hready;
        req_ready = ~err2_q & (~aph_valid_q | (hready & ~err_first));
        accept    = req_valid & req_ready;
        done      = dph_valid_q & hready;

        aph_valid_d = aph_valid_q;
        aph_addr_d  = aph_addr_q;
        aph_size_d  = aph_size_q;
        aph_write_d = aph_write_q;
        aph_wdata_d = aph_wdata_q;
        dph_valid_d = dph_valid_q;
        dph_write_d = dph_write_q;
        dph_wdata_d = dph_wdata_q;
        err2_d      = err2_q;

        if (err2_q) begin
            // Second ERROR cycle: drop the failed data phase, keep the cancelled APH for re-issue.
            if (hready) begin
                dph_valid_d = 1'b0;
                err2_d      = 1'b0;
            end
        end else if (hready) begin
            dph_valid_d = aph_valid_q;
            dph_write_d = aph_write_q;
            dph_wdata_d = aph_wdata_q;
            aph_valid_d = accept;
        end else if (err_first) begin
            err2_d = 1'b1;
        end

        // accept during a wait state is only possible into an empty APH
        if (accept) begin
            aph_valid_d = 1'b1;
            aph_addr_d  = req_addr;
            aph_size_d  = req_size;
            aph_write_d = req_write;
            aph_wdata_d = req_wdata;
        end

        rsp_valid_d = done;
        rsp_err_d   = done & hresp;
        rsp_rdata_d = (done & ~dph_write_q) ? hrdata : '0;
    end

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            aph_valid_q <= 1'b0;
            aph_addr_q  <= '0;
            aph_size_q  <= '0;
            aph_write_q <= 1'b0;
            aph_wdata_q <= '0;
            dph_valid_q <= 1'b0;
            dph_write_q <= 1'b0;
            dph_wdata_q <= '0;
            err2_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            aph_valid_q <= aph_valid_d;
            aph_addr_q  <= aph_addr_d;
            aph_size_q  <= aph_size_d;
            aph_write_q <= aph_write_d;
            aph_wdata_q <= aph_wdata_d;
            dph_valid_q <= dph_valid_d;
            dph_write_q <= dph_write_d;
            dph_wdata_q <= dph_wdata_d;
            err2_q      <= err2_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign htrans    = (aph_valid_q & ~err2_q) ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign haddr     = aph_valid_q ? aph_addr_q : '0;
    assign hsize     = aph_valid_q ? aph_size_q : '0;
    assign hwrite    = aph_valid_q & aph_write_q;
    assign hwdata    = (dph_valid_q & dph_write_q) ? dph_wdata_q : '0;
    assign hburst    = HBURST_SINGLE;
    assign hprot     = HPROT_DATA_PRIV;
    assign hmastlock = 1'b0;

    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;

    a_req_legal : assert property (@(posedge hclk) disable iff (hreset)
        req_valid |-> (is_aligned(req_addr[7:0], req_size) && (req_size <= 3'(MAX_SIZE))));

endmodule

// File: tb/tb_ahb_lite_req_master.sv
// Directed bench for ahb_lite_req_master with a small behavioural AHB-Lite memory slave
// supporting programmable wait states and a two-cycle ERROR response.
module tb_ahb_lite_req_master;

    logic        hclk = 1'b0;
    logic        hreset;
    logic        req_valid, req_ready, req_write;
    logic [31:0] req_addr, req_wdata;
    logic [2:0]  req_size;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic [1:0]  htrans;
    logic [2:0]  hburst, hsize;
    logic [3:0]  hprot;
    logic        hmastlock, hwrite;
    logic [31:0] haddr, hwdata, hrdata;
    logic        hresp, hready;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    ahb_lite_req_master #(.ADDR(32), .DATA(32)) dut (
        .hclk(hclk), .hreset(hreset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .htrans(htrans), .hburst(hburst), .hsize(hsize), .hprot(hprot),
        .hmastlock(hmastlock), .haddr(haddr), .hwrite(hwrite), .hwdata(hwdata),
        .hrdata(hrdata), .hresp(hresp), .hready(hready)
    );

    always #5 hclk = ~hclk;
    always @(posedge hclk) cyc <= cyc + 1;

    // ---------------- behavioural slave ----------------
    logic [31:0] mem [0:63];
    logic        s_act, s_wr;
    logic [31:0] s_addr;
    logic [2:0]  s_size;
    int          s_wait;
    logic [1:0]  s_err;
    logic        ws_en, err_en;
    logic [31:0] ws_addr, err_addr;
    int          ws_n;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [1:0] a, input logic [2:0] sz);
        logic [31:0] r;
        int b;
        r = old;
        b = int'(a);
        case (sz)
            3'd0:    r[b*8 +: 8] = wd[b*8 +: 8];
            3'd1:    r[(b/2)*16 +: 16] = wd[(b/2)*16 +: 16];
            default: r = wd;
        endcase
        return r;
    endfunction

    always_comb begin
        hready = 1'b1;
        hresp  = 1'b0;
        hrdata = 32'hA5A5_A5A5;
        if (s_act) begin
            if (s_err == 2'd1) begin
                hready = 1'b0;
                hresp  = 1'b1;
            end else if (s_err == 2'd2) begin
                hresp  = 1'b1;
            end else begin
                hready = (s_wait == 0);
            end
            if (!s_wr) hrdata = mem[s_addr[7:2]];
        end
    end

    always @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            s_act  <= 1'b0;
            s_wait <= 0;
            s_err  <= 2'd0;
        end else if (hready) begin
            if (s_act && s_wr && s_err == 2'd0)
                mem[s_addr[7:2]] <= merge(mem[s_addr[7:2]], hwdata, s_addr[1:0], s_size);
            if (htrans == 2'b10) begin
                s_act  <= 1'b1;
                s_addr <= haddr;
                s_wr   <= hwrite;
                s_size <= hsize;
                s_wait <= (ws_en && haddr == ws_addr) ? ws_n : 0;
                s_err  <= (err_en && haddr == err_addr) ? 2'd1 : 2'd0;
            end else begin
                s_act <= 1'b0;
            end
        end else begin
            if (s_wait > 0) s_wait <= s_wait - 1;
            if (s_err == 2'd1) s_err <= 2'd2;
        end
    end

    // ---------------- monitors ----------------
    typedef struct {
        int          cyc;
        logic        err;
        logic [31:0] rdata;
    } rsp_t;

    rsp_t        rsp_q[$];
    int          acc_q[$];
    int          runs_q[$];
    int          run = 0;
    int          nonseq_cnt = 0;
    int          stall_cnt = 0;
    int          freeze_viol = 0;
    logic        p_stall = 1'b0;
    logic [1:0]  p_htrans;
    logic [31:0] p_haddr;
    logic [2:0]  p_hsize;

    always @(negedge hclk) begin
        rsp_t r;
        if (rsp_valid) begin
            r.cyc = cyc;
            r.err = rsp_err;
            r.rdata = rsp_rdata;
            rsp_q.push_back(r);
        end
        if (req_valid && req_ready && !hreset) acc_q.push_back(cyc);
        if (htrans == 2'b10) begin
            run++;
            nonseq_cnt++;
        end else if (run > 0) begin
            runs_q.push_back(run);
            run = 0;
        end
        if (p_stall && (htrans !== p_htrans || haddr !== p_haddr || hsize !== p_hsize))
            freeze_viol++;
        if (htrans == 2'b10 && !hready) stall_cnt++;
        p_stall  = (htrans == 2'b10) && !hready;
        p_htrans = htrans;
        p_haddr  = haddr;
        p_hsize  = hsize;
    end

    function automatic logic [31:0] pat(input int i);
        return 32'hC0DE_0000 + 32'(i * 17);
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge hclk);
            #1;
        end
    endtask

    task automatic do_req(input logic w, input logic [31:0] a, input logic [2:0] s, input logic [31:0] d);
        bit got;
        got = 0;
        req_write = w;
        req_addr  = a;
        req_size  = s;
        req_wdata = d;
        req_valid = 1'b1;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge hclk);
            if (req_ready) got = 1;
            @(posedge hclk);
            #1;
        end
        req_valid = 1'b0;
        vectors++;
        if (!got) begin
            miscompares++;
            $display("FAIL req_accept addr=%h: got no acceptance, required within 40 cycles", a);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        hreset = 1'b1;
        #3;
        vectors += 10;
        if (htrans !== 2'b00)      begin miscompares++; $display("FAIL rst_htrans got %h want 0", htrans); end
        if (haddr !== 32'h0)       begin miscompares++; $display("FAIL rst_haddr got %h want 0", haddr); end
        if (hwdata !== 32'h0)      begin miscompares++; $display("FAIL rst_hwdata got %h want 0", hwdata); end
        if (rsp_valid !== 1'b0)    begin miscompares++; $display("FAIL rst_rsp_valid got %b want 0", rsp_valid); end
        if (rsp_rdata !== 32'h0)   begin miscompares++; $display("FAIL rst_rsp_rdata got %h want 0", rsp_rdata); end
        if (rsp_err !== 1'b0)      begin miscompares++; $display("FAIL rst_rsp_err got %b want 0", rsp_err); end
        if (req_ready !== 1'b1)    begin miscompares++; $display("FAIL rst_req_ready got %b want 1", req_ready); end
        if (hburst !== 3'b000)     begin miscompares++; $display("FAIL rst_hburst got %h want 0", hburst); end
        if (hprot !== 4'b0011)     begin miscompares++; $display("FAIL rst_hprot got %h want 3", hprot); end
        if (hmastlock !== 1'b0)    begin miscompares++; $display("FAIL rst_hmastlock got %b want 0", hmastlock); end
        repeat (2) @(posedge hclk);
        #1 hreset = 1'b0;
        @(negedge hclk);
        vectors++;
        if (htrans !== 2'b00 || req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL post_rst_idle got htrans=%h ready=%b rsp_valid=%b want 0/1/0", htrans, req_ready, rsp_valid);
        end
        @(posedge hclk);
        #1;
    endtask

    task automatic test_single;
        int rb, ab, nb;
        rb = rsp_q.size(); ab = acc_q.size(); nb = nonseq_cnt;
        do_req(1'b1, 32'h10, 3'd2, 32'hDEAD_BEEF);
        @(negedge hclk);
        vectors++;
        if (htrans !== 2'b10 || haddr !== 32'h10 || hwrite !== 1'b1 || hsize !== 3'd2) begin
            miscompares++;
            $display("FAIL single_wr_aph got htrans=%h haddr=%h hwrite=%b hsize=%h want 2/10/1/2", htrans, haddr, hwrite, hsize);
        end
        @(posedge hclk); #1;
        @(negedge hclk);
        vectors++;
        if (hwdata !== 32'hDEAD_BEEF || htrans !== 2'b00) begin
            miscompares++;
            $display("FAIL single_wr_dph got hwdata=%h htrans=%h want deadbeef/0", hwdata, htrans);
        end
        idle(4);
        do_req(1'b0, 32'h10, 3'd2, 32'h0);
        @(negedge hclk);
        vectors++;
        if (htrans !== 2'b10 || haddr !== 32'h10 || hwrite !== 1'b0) begin
            miscompares++;
            $display("FAIL single_rd_aph got htrans=%h haddr=%h hwrite=%b want 2/10/0", htrans, haddr, hwrite);
        end
        idle(5);
        vectors += 2;
        if (nonseq_cnt - nb != 2) begin
            miscompares++;
            $display("FAIL single_nonseq_cycles got %0d want 2", nonseq_cnt - nb);
        end
        if (rsp_q.size() - rb != 2) begin
            miscompares++;
            $display("FAIL single_rsp_count got %0d want 2", rsp_q.size() - rb);
        end else begin
            for (int k = 0; k < 2; k++) begin
                vectors++;
                if (rsp_q[rb+k].cyc - acc_q[ab+k] != 3) begin
                    miscompares++;
                    $display("FAIL single_latency[%0d] got %0d want 3", k, rsp_q[rb+k].cyc - acc_q[ab+k]);
                end
            end
            vectors += 2;
            if (rsp_q[rb].rdata !== 32'h0 || rsp_q[rb].err !== 1'b0) begin
                miscompares++;
                $display("FAIL single_wr_rsp got rdata=%h err=%b want 0/0", rsp_q[rb].rdata, rsp_q[rb].err);
            end
            if (rsp_q[rb+1].rdata !== 32'hDEAD_BEEF || rsp_q[rb+1].err !== 1'b0) begin
                miscompares++;
                $display("FAIL single_rd_rsp got rdata=%h err=%b want deadbeef/0", rsp_q[rb+1].rdata, rsp_q[rb+1].err);
            end
        end
    endtask

    task automatic test_back_to_back;
        int rb, runb, miss, got_run;
        logic [31:0] exp;
        rb = rsp_q.size(); runb = runs_q.size(); miss = 0;
        for (int i = 0; i < 16; i++) begin
            req_write = (i < 8);
            req_addr  = 32'((i % 8) * 4);
            req_size  = 3'd2;
            req_wdata = (i < 8) ? pat(i) : 32'h0;
            req_valid = 1'b1;
            @(negedge hclk);
            if (!req_ready) miss++;
            @(posedge hclk); #1;
        end
        req_valid = 1'b0;
        idle(6);
        got_run = (runs_q.size() > runb) ? runs_q[runb] : 0;
        vectors += 3;
        if (miss != 0) begin miscompares++; $display("FAIL b2b_ready_gaps got %0d want 0", miss); end
        if (got_run != 16) begin miscompares++; $display("FAIL b2b_nonseq_run got %0d want 16", got_run); end
        if (rsp_q.size() - rb != 16) begin
            miscompares++;
            $display("FAIL b2b_rsp_count got %0d want 16", rsp_q.size() - rb);
        end else begin
            for (int k = 0; k < 16; k++) begin
                exp = (k < 8) ? 32'h0 : pat(k - 8);
                vectors++;
                if (rsp_q[rb+k].rdata !== exp || rsp_q[rb+k].err !== 1'b0) begin
                    miscompares++;
                    $display("FAIL b2b_rsp[%0d] got rdata=%h err=%b want %h/0", k, rsp_q[rb+k].rdata, rsp_q[rb+k].err, exp);
                end
            end
        end
    endtask

    task automatic test_wait_states;
        int rb, sb, fb;
        ws_en = 1'b1; ws_addr = 32'h4; ws_n = 2;
        rb = rsp_q.size(); sb = stall_cnt; fb = freeze_viol;
        do_req(1'b0, 32'h0, 3'd2, 32'h0);
        do_req(1'b0, 32'h4, 3'd2, 32'h0);
        do_req(1'b0, 32'h8, 3'd2, 32'h0);
        idle(8);
        ws_en = 1'b0;
        vectors += 3;
        if (stall_cnt - sb != 2) begin miscompares++; $display("FAIL ws_stall_cycles got %0d want 2", stall_cnt - sb); end
        if (freeze_viol - fb != 0) begin miscompares++; $display("FAIL ws_aph_frozen got %0d changes want 0", freeze_viol - fb); end
        if (rsp_q.size() - rb != 3) begin
            miscompares++;
            $display("FAIL ws_rsp_count got %0d want 3", rsp_q.size() - rb);
        end else begin
            for (int k = 0; k < 3; k++) begin
                vectors++;
                if (rsp_q[rb+k].rdata !== pat(k) || rsp_q[rb+k].err !== 1'b0) begin
                    miscompares++;
                    $display("FAIL ws_rsp[%0d] got rdata=%h err=%b want %h/0", k, rsp_q[rb+k].rdata, rsp_q[rb+k].err, pat(k));
                end
            end
        end
    endtask

    task automatic test_error;
        int rb;
        do_req(1'b1, 32'h44, 3'd2, 32'h4444_5555);
        idle(4);
        err_en = 1'b1; err_addr = 32'h40;
        rb = rsp_q.size();
        do_req(1'b0, 32'h40, 3'd2, 32'h0);
        do_req(1'b0, 32'h44, 3'd2, 32'h0);
        @(negedge hclk);
        vectors += 2;
        if (htrans !== 2'b10 || haddr !== 32'h44) begin
            miscompares++;
            $display("FAIL err_c1_aph got htrans=%h haddr=%h want 2/44", htrans, haddr);
        end
        if (req_ready !== 1'b0) begin miscompares++; $display("FAIL err_c1_ready got %b want 0", req_ready); end
        @(posedge hclk); #1;
        @(negedge hclk);
        vectors++;
        if (htrans !== 2'b00) begin miscompares++; $display("FAIL err_c2_htrans got %h want 0", htrans); end
        @(posedge hclk); #1;
        @(negedge hclk);
        vectors++;
        if (htrans !== 2'b10 || haddr !== 32'h44) begin
            miscompares++;
            $display("FAIL err_reissue got htrans=%h haddr=%h want 2/44", htrans, haddr);
        end
        idle(6);
        err_en = 1'b0;
        vectors++;
        if (rsp_q.size() - rb != 2) begin
            miscompares++;
            $display("FAIL err_rsp_count got %0d want 2", rsp_q.size() - rb);
        end else begin
            vectors += 2;
            if (rsp_q[rb].err !== 1'b1) begin miscompares++; $display("FAIL err_rsp_40 got err=%b want 1", rsp_q[rb].err); end
            if (rsp_q[rb+1].err !== 1'b0 || rsp_q[rb+1].rdata !== 32'h4444_5555) begin
                miscompares++;
                $display("FAIL err_rsp_44 got err=%b rdata=%h want 0/44445555", rsp_q[rb+1].err, rsp_q[rb+1].rdata);
            end
        end
    endtask

    task automatic test_byte_write;
        int rb;
        rb = rsp_q.size();
        do_req(1'b1, 32'h13, 3'd0, 32'h5A00_0000);
        @(negedge hclk);
        vectors++;
        if (htrans !== 2'b10 || haddr !== 32'h13 || hsize !== 3'd0) begin
            miscompares++;
            $display("FAIL byte_aph got htrans=%h haddr=%h hsize=%h want 2/13/0", htrans, haddr, hsize);
        end
        @(posedge hclk); #1;
        @(negedge hclk);
        vectors++;
        if (hwdata !== 32'h5A00_0000) begin miscompares++; $display("FAIL byte_hwdata got %h want 5a000000", hwdata); end
        idle(3);
        do_req(1'b0, 32'h10, 3'd2, 32'h0);
        idle(5);
        vectors++;
        if (rsp_q.size() - rb != 2) begin
            miscompares++;
            $display("FAIL byte_rsp_count got %0d want 2", rsp_q.size() - rb);
        end else begin
            vectors += 2;
            if (rsp_q[rb].err !== 1'b0) begin miscompares++; $display("FAIL byte_rsp_err got %b want 0", rsp_q[rb].err); end
            if (rsp_q[rb+1].rdata !== 32'h5ADE_0044) begin
                miscompares++;
                $display("FAIL byte_readback got %h want 5ade0044", rsp_q[rb+1].rdata);
            end
        end
    endtask

    task automatic test_reset_midflight;
        int rb, ab;
        rb = rsp_q.size();
        do_req(1'b1, 32'h20, 3'd2, 32'h1122_3344);
        @(posedge hclk); #1;
        vectors++;
        if (hwdata !== 32'h1122_3344) begin miscompares++; $display("FAIL mid_dph_hwdata got %h want 11223344", hwdata); end
        #1 hreset = 1'b1;
        #1;
        vectors += 4;
        if (htrans !== 2'b00)    begin miscompares++; $display("FAIL mid_rst_htrans got %h want 0", htrans); end
        if (hwdata !== 32'h0)    begin miscompares++; $display("FAIL mid_rst_hwdata got %h want 0", hwdata); end
        if (haddr !== 32'h0)     begin miscompares++; $display("FAIL mid_rst_haddr got %h want 0", haddr); end
        if (req_ready !== 1'b1)  begin miscompares++; $display("FAIL mid_rst_ready got %b want 1", req_ready); end
        repeat (2) @(posedge hclk);
        #1 hreset = 1'b0;
        idle(3);
        vectors++;
        if (rsp_q.size() - rb != 0) begin miscompares++; $display("FAIL mid_rst_no_rsp got %0d responses want 0", rsp_q.size() - rb); end
        rb = rsp_q.size(); ab = acc_q.size();
        do_req(1'b1, 32'h18, 3'd2, 32'hCAFE_F00D);
        @(negedge hclk);
        vectors++;
        if (htrans !== 2'b10 || haddr !== 32'h18 || hwrite !== 1'b1) begin
            miscompares++;
            $display("FAIL post_rst_aph got htrans=%h haddr=%h hwrite=%b want 2/18/1", htrans, haddr, hwrite);
        end
        idle(5);
        vectors++;
        if (rsp_q.size() - rb != 1) begin
            miscompares++;
            $display("FAIL post_rst_rsp_count got %0d want 1", rsp_q.size() - rb);
        end else begin
            vectors++;
            if (rsp_q[rb].cyc - acc_q[ab] != 3 || rsp_q[rb].err !== 1'b0 || rsp_q[rb].rdata !== 32'h0) begin
                miscompares++;
                $display("FAIL post_rst_rsp got lat=%0d err=%b rdata=%h want 3/0/0",
                         rsp_q[rb].cyc - acc_q[ab], rsp_q[rb].err, rsp_q[rb].rdata);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        hreset    = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = 32'h0;
        req_size  = 3'd2;
        req_wdata = 32'h0;
        ws_en     = 1'b0;
        ws_addr   = 32'h0;
        ws_n      = 0;
        err_en    = 1'b0;
        err_addr  = 32'h0;
        test_reset;
        test_single;
        test_back_to_back;
        test_wait_states;
        test_error;
        test_byte_write;
        test_reset_midflight;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ahb_lite_req_master.md
Name: ahb_lite_req_master

Overview:
- Single-beat AHB-Lite master that converts a simple valid/ready request stream into pipelined AHB-Lite NONSEQ/SINGLE transfers toward the mem slave.
- Returns in-order responses (read data, error flag) on a no-backpressure response port.
- Sits directly upstream of mem; its address/control/write-data outputs drive mem's AHB inputs, and hready is mem's hreadyout (single-slave system, hsel tied high externally).

Parameters:
- ADDR, 32, address width.
- DATA, 32, data width; legal req_size values are 0 .. log2(DATA/8).

Ports:
- hclk  in  1  clock.
- hreset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted this cycle when req_valid & req_ready.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR  byte address; the requester guarantees it is aligned to req_size.
- req_size  in  3  HSIZE encoding.
- req_wdata  in  DATA  write data.
- rsp_valid  out  1  one-cycle pulse per completed transfer.
- rsp_rdata  out  DATA  read data; 0 for writes.
- rsp_err  out  1  transfer ended with ERROR.
- htrans  out  2  IDLE=0 / NONSEQ=2 only.
- hburst  out  3  constant SINGLE (0).
- hsize  out  3  address-phase size.
- hprot  out  4  constant 4'b0011.
- hmastlock  out  1  constant 0.
- haddr  out  ADDR  address-phase address.
- hwrite  out  1  address-phase direction.
- hwdata  out  DATA  data-phase write data.
- hrdata  in  DATA  read data.
- hresp  in  1  0 = OKAY, 1 = ERROR.
- hready  in  1  bus ready.

Behaviour:
- One clock, hclk; reset hreset is asynchronous and active-high. All state clears immediately on assertion; in-flight transfers are dropped and produce no response.
- Two register stages:
  - APH (address phase): aph_valid, addr, size, write, wdata.
  - DPH (data phase): dph_valid, write, wdata.
  - Plus an err2 flag.
- Outputs:
  - htrans = NONSEQ when aph_valid & ~err2, else IDLE.
  - haddr/hsize/hwrite come from APH. When aph_valid=0, drive haddr=0, hsize=0, hwrite=0.
  - hwdata = dph_wdata when dph_valid & dph_write, else 0.
- req_ready = ~err2 & (~aph_valid | (hready & ~err_first)), where err_first = dph_valid & hresp & ~hready.
- On hready=1 with err2=0:
  - DPH <= APH.
  - APH <= accepted request, or aph_valid <= 0 if none accepted.
- On hready=0: APH and DPH hold. Address outputs stay stable, as the protocol requires.
- Completion: dph_valid & hready in a cycle. The next cycle gives rsp_valid=1, rsp_err=hresp, and rsp_rdata=hrdata for reads (0 for writes). Latency from request acceptance to rsp_valid is 3 cycles with zero wait states.
- Back-to-back throughput is 1 transfer/cycle; address phase of N+1 overlaps data phase of N.
- ERROR handling (two-cycle response):
  - Cycle 1 (hresp=1, hready=0): set err2.
  - Cycle 2 (err2=1): htrans forced IDLE, cancelling any pending APH transfer. When hready=1, DPH completes with rsp_err=1, DPH <= empty, APH retained, err2 cleared.
  - The retained APH transfer is re-issued as NONSEQ the following cycle. Response order is preserved; no request is lost.
- Reset deasserted: all outputs at reset values (htrans=IDLE, haddr=0, hwdata=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, req_ready=1).
- Simultaneous request acceptance and completion in one cycle: both take effect.
- Assertion: req_addr aligned to req_size; req_size ≤ log2(DATA/8).

Decomposition:
- ahb_names_pkg gains HTRANS_IDLE/HTRANS_NONSEQ, HBURST_SINGLE, HSIZE_BYTE/HALF/WORD, HPROT_DATA_PRIV (4'b0011), alongside the existing HRESP_OKAY/HRESP_ERROR.
- Widths come from mem_verif_param_pkg.
- No sub-module; a single module of two pipeline stages plus err2.

Test Plan:
- Single write 0x10 ← 0xDEADBEEF then read 0x10 against mem, zero wait:
  - htrans NONSEQ one cycle each.
  - rsp_valid 3 cycles after each acceptance.
  - read rsp_rdata=0xDEADBEEF, rsp_err=0.
- 8 back-to-back writes 0x0..0x1C followed by 8 reads, req_valid held high:
  - req_ready continuously 1, htrans NONSEQ 16 consecutive cycles.
  - 16 responses in order, reads return the written data.
- Slave inserts 2 wait states on the second of three reads:
  - haddr/htrans/hsize frozen while hready=0.
  - Exactly 3 in-order responses, none duplicated.
- ERROR on read 0x40 with read 0x44 pending in APH:
  - Cycle 2 shows htrans=IDLE.
  - rsp_err=1 for 0x40.
  - 0x44 re-issued next cycle, completes with rsp_err=0.
- hreset asserted while a write is in its data phase:
  - Outputs return to reset values asynchronously.
  - No rsp_valid pulse; the first post-reset request behaves as in the single-write scenario.
- Byte write hsize=0 at 0x13 with wdata 0x5A000000:
  - haddr=0x13, hsize=0, hwdata=0x5A000000 in the data phase.
  - rsp_err=0.
